block_state_store: RTL and testbench

BLOCK_STATE_STORE -- requirements
Module: block_state_store

---
 rtl/block_state_store_pkg.sv | 21 ++
 rtl/block_state_store_row_mem.sv | 35 +++
 rtl/block_state_store.sv | 154 +++++++++++++++
 tb/tb_block_state_store.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_state_store_pkg.sv
// Shared breakout parameters: field geometry, derived block count, store FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package block_state_store_pkg;

  localparam int DEF_BLOCKS_PER_ROW = 13;
  localparam int DEF_NUM_ROWS       = 16;
  localparam int TOTAL_BLOCKS       = DEF_BLOCKS_PER_ROW * DEF_NUM_ROWS;

  // Width of the clear_row / clear_col request indices.
  localparam int IDX_W   = 4;
  // Width of the remaining-block counter (holds 0..TOTAL_BLOCKS).
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } bss_state_t;

endpackage

// File: rtl/block_state_store_row_mem.sv
// Block presence register file: NUM_ROWS words of BLOCKS_PER_ROW bits.
// Latency: writes land on the next clk edge; both reads are combinational.
// Backpressure: none; one write per cycle, always accepted.
// Ports: wr_en/wr_row/wr_data = write port; disp_row/disp_data = display read;
//        chk_row/chk_data = clear-check read.
module block_row_mem #(
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int ROW_W          = $clog2(NUM_ROWS)
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      wr_en,
  input  logic [ROW_W-1:0]          wr_row,
  input  logic [BLOCKS_PER_ROW-1:0] wr_data,
  input  logic [ROW_W-1:0]          disp_row,
  output logic [BLOCKS_PER_ROW-1:0] disp_data,
  input  logic [ROW_W-1:0]          chk_row,
  output logic [BLOCKS_PER_ROW-1:0] chk_data
);

  logic [BLOCKS_PER_ROW-1:0] mem [NUM_ROWS];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NUM_ROWS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign disp_data = mem[disp_row];
  assign chk_data  = mem[chk_row];

endmodule

// File: rtl/block_state_store.sv
// Breakout block field store: display row readout, block clear handshake, level refill.
// Latency: clear_req -> clear_ack 1 cycle; refill sweep NUM_ROWS cycles; row readout combinational.
// Backpressure: clear_req is a held level, serviced in IDLE only; acks are at least 2 cycles apart.
// Ports: new_frame/go_next_line move the display row pointer, block_line_state is that row;
//        clear_req/clear_row/clear_col -> clear_ack/clear_hit; level_init -> init_busy sweep;
//        blocks_remaining/all_cleared report the field population.
module block_state_store
  import block_state_store_pkg::*;
#(
  parameter int BLOCKS_PER_ROW = DEF_BLOCKS_PER_ROW,
  parameter int NUM_ROWS       = DEF_NUM_ROWS
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  input  logic                      clear_req,
  input  logic [IDX_W-1:0]          clear_row,
  input  logic [IDX_W-1:0]          clear_col,
  output logic                      clear_ack,
  output logic                      clear_hit,
  input  logic                      level_init,
  output logic                      init_busy,
  output logic [COUNT_W-1:0]        blocks_remaining,
  output logic                      all_cleared
);

  localparam int              ROW_W    = $clog2(NUM_ROWS);
  localparam int              TOTAL    = NUM_ROWS * BLOCKS_PER_ROW;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  bss_state_t                state;
  logic [ROW_W-1:0]          row_ptr;
  logic [ROW_W-1:0]          init_idx;
  logic [ROW_W-1:0]          lat_row;
  logic [BLOCKS_PER_ROW-1:0] lat_mask;
  logic                      ack_q;
  logic                      hit_q;
  logic [COUNT_W-1:0]        count;

  logic                      wr_en;
  logic [ROW_W-1:0]          wr_row;
  logic [BLOCKS_PER_ROW-1:0] wr_data;
  logic [ROW_W-1:0]          chk_row;
  logic [BLOCKS_PER_ROW-1:0] chk_data;
  logic [BLOCKS_PER_ROW-1:0] req_mask;
  logic                      req_hit;

  block_row_mem #(
    .BLOCKS_PER_ROW (BLOCKS_PER_ROW),
    .NUM_ROWS       (NUM_ROWS),
    .ROW_W          (ROW_W)
  ) u_row_mem (
    .clk       (clk),
    .nRst      (nRst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .disp_row  (row_ptr),
    .disp_data (block_line_state),
    .chk_row   (chk_row),
    .chk_data  (chk_data)
  );

  // Column decode; columns beyond the row width select nothing and so never hit.
  always_comb begin
    req_mask = '0;
    if (int'(clear_col) < BLOCKS_PER_ROW) req_mask[clear_col] = 1'b1;
  end

  // The hit is resolved while still in IDLE, straight from the request inputs, so
  // ack and hit leave registers. Storage cannot change between that cycle and CLEAR.
  // In CLEAR the check port re-reads the latched row to build the write-back word.
  assign chk_row = (state == ST_CLEAR) ? lat_row : clear_row[ROW_W-1:0];
  assign req_hit = |(chk_data & req_mask);

  always_comb begin
    wr_en   = 1'b0;
    wr_row  = init_idx;
    wr_data = '1;
    if (state == ST_INIT) begin
      wr_en = 1'b1;
    end else if (state == ST_CLEAR && hit_q && !level_init) begin
      wr_en   = 1'b1;
      wr_row  = lat_row;
      wr_data = chk_data & ~lat_mask;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state    <= ST_INIT;
      init_idx <= '0;
      lat_row  <= '0;
      lat_mask <= '0;
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      count    <= '0;
    end else begin
      ack_q <= 1'b0;
      hit_q <= 1'b0;
      if (level_init) begin
        state    <= ST_INIT;
        init_idx <= '0;
        count    <= '0;
      end else begin
        case (state)
          ST_INIT: begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == LAST_ROW) begin
              state    <= ST_IDLE;
              init_idx <= '0;
              count    <= COUNT_W'(TOTAL);
            end
          end
          ST_IDLE: begin
            if (clear_req) begin
              state    <= ST_CLEAR;
              lat_row  <= clear_row[ROW_W-1:0];
              lat_mask <= req_mask;
              ack_q    <= 1'b1;
              hit_q    <= req_hit;
            end
          end
          ST_CLEAR: begin
            state <= ST_IDLE;
            if (hit_q && count != '0) count <= count - 1'b1;
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_ptr <= '0;
    end else if (new_frame) begin
      row_ptr <= '0;
    end else if (go_next_line) begin
      row_ptr <= (row_ptr == LAST_ROW) ? '0 : row_ptr + 1'b1;
    end
  end

  // A refill pulse landing in the CLEAR cycle aborts that clear: ack and hit are
  // masked here and the write-back is suppressed above.
  assign clear_ack        = ack_q & ~level_init;
  assign clear_hit        = hit_q & ~level_init;
  assign init_busy        = (state == ST_INIT);
  assign blocks_remaining = count;
  assign all_cleared      = (state != ST_INIT) && (count == '0);

endmodule

// File: tb/tb_block_state_store.sv
module tb_block_state_store;

  logic        clk = 1'b0;
  logic        nRst;
  logic        new_frame;
  logic        go_next_line;
  logic [12:0] block_line_state;
  logic        clear_req;
  logic [3:0]  clear_row;
  logic [3:0]  clear_col;
  logic        clear_ack;
  logic        clear_hit;
  logic        level_init;
  logic        init_busy;
  logic [7:0]  blocks_remaining;
  logic        all_cleared;

  block_state_store dut (
    .clk              (clk),
    .nRst             (nRst),
    .new_frame        (new_frame),
    .go_next_line     (go_next_line),
    .block_line_state (block_line_state),
    .clear_req        (clear_req),
    .clear_row        (clear_row),
    .clear_col        (clear_col),
    .clear_ack        (clear_ack),
    .clear_hit        (clear_hit),
    .level_init       (level_init),
    .init_busy        (init_busy),
    .blocks_remaining (blocks_remaining),
    .all_cleared      (all_cleared)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the field as a plain bit array, a population count, and the row pointer.
  logic [12:0] m_rows [16];
  int          m_count;
  int          m_ptr;

  function automatic void model_fill();
    for (int r = 0; r < 16; r++) m_rows[r] = 13'h1FFF;
    m_count = 208;
  endfunction

  function automatic bit model_clear(input int r, input int c);
    bit h = 1'b0;
    if (c < 13) begin
      if (m_rows[r][c]) begin
        h = 1'b1;
        m_rows[r][c] = 1'b0;
        if (m_count > 0) m_count--;
      end
    end
    return h;
  endfunction

  // Called on a falling edge; returns on the falling edge after the pointer update.
  task automatic pulse_ptr(input bit nf, input bit gnl);
    new_frame    = nf;
    go_next_line = gnl;
    @(negedge clk);
    new_frame    = 1'b0;
    go_next_line = 1'b0;
    if (nf) m_ptr = 0;
    else if (gnl) m_ptr = (m_ptr + 1) % 16;
  endtask

  // Raise a request, wait (bounded) for the ack, drop the request, let the write land.
  task automatic do_clear(input int r, input int c, output bit acked, output bit hit, output int lat);
    clear_row = 4'(r);
    clear_col = 4'(c);
    clear_req = 1'b1;
    acked = 1'b0;
    hit   = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 6 && !acked; i++) begin
      @(negedge clk);
      if (clear_ack === 1'b1) begin
        acked = 1'b1;
        hit   = clear_hit;
        lat   = i;
      end
    end
    clear_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int busy;
    nRst = 1'b0; new_frame = 1'b0; go_next_line = 1'b0; clear_req = 1'b0;
    clear_row = '0; clear_col = '0; level_init = 1'b0;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    n_checks++; if (clear_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", clear_ack); end
    n_checks++; if (clear_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b expected 0", clear_hit); end
    n_checks++; if (blocks_remaining !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", blocks_remaining); end
    n_checks++; if (all_cleared !== 1'b0) begin n_fail++; $display("FAIL reset_all_cleared: got %b expected 0", all_cleared); end
    n_checks++; if (block_line_state !== 13'h0) begin n_fail++; $display("FAIL reset_line: got %h expected 0000", block_line_state); end
    nRst = 1'b1;
    n_checks++; if (all_cleared !== 1'b0) begin n_fail++; $display("FAIL init_all_cleared: got %b expected 0", all_cleared); end
    busy = 0;
    for (int i = 0; i < 40 && init_busy === 1'b1; i++) begin
      busy++;
      @(negedge clk);
    end
    model_fill();
    n_checks++; if (busy != 16) begin n_fail++; $display("FAIL init_busy_cycles: got %0d expected 16", busy); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL init_count: got %0d expected %0d", blocks_remaining, m_count); end
    n_checks++; if (all_cleared !== 1'b0) begin n_fail++; $display("FAIL post_init_all_cleared: got %b expected 0", all_cleared); end
    pulse_ptr(1'b1, 1'b0);
    for (int r = 0; r < 16; r++) begin
      n_checks++;
      if (block_line_state !== m_rows[r]) begin n_fail++; $display("FAIL init_row%0d: got %h expected %h", r, block_line_state, m_rows[r]); end
      pulse_ptr(1'b0, 1'b1);
    end
  endtask

  task automatic test_single_clear();
    bit a, h, e; int lat;
    do_clear(2, 5, a, h, lat);
    e = model_clear(2, 5);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL single_ack: got %b expected 1", a); end
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d expected 1", lat); end
    n_checks++; if (h !== e) begin n_fail++; $display("FAIL single_hit: got %b expected %b", h, e); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", blocks_remaining, m_count); end
    pulse_ptr(1'b1, 1'b0);
    pulse_ptr(1'b0, 1'b1);
    pulse_ptr(1'b0, 1'b1);
    n_checks++; if (block_line_state !== 13'h1FDF) begin n_fail++; $display("FAIL single_row2: got %h expected 1fdf", block_line_state); end
  endtask

  task automatic test_miss();
    bit a, h, e; int lat;
    do_clear(2, 5, a, h, lat);
    e = model_clear(2, 5);
    n_checks++; if (a !== 1'b1 || h !== e) begin n_fail++; $display("FAIL repeat_clear: got ack %b hit %b expected ack 1 hit %b", a, h, e); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL repeat_count: got %0d expected %0d", blocks_remaining, m_count); end
    do_clear(4, 13, a, h, lat);
    e = model_clear(4, 13);
    n_checks++; if (a !== 1'b1 || h !== e) begin n_fail++; $display("FAIL col13_clear: got ack %b hit %b expected ack 1 hit %b", a, h, e); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL col13_count: got %0d expected %0d", blocks_remaining, m_count); end
  endtask

  task automatic test_random_clears();
    bit a, h, e; int lat, r, c;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 15);
      c = $urandom_range(0, 15);
      do_clear(r, c, a, h, lat);
      e = model_clear(r, c);
      n_checks++;
      if (a !== 1'b1 || lat != 1 || h !== e) begin
        n_fail++; $display("FAIL rand_clear r%0d c%0d: got ack %b lat %0d hit %b expected ack 1 lat 1 hit %b", r, c, a, lat, h, e);
      end
      n_checks++;
      if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", blocks_remaining, m_count); end
    end
  endtask

  task automatic test_row_pointer();
    bit nf, gnl;
    pulse_ptr(1'b1, 1'b0);
    repeat (3) pulse_ptr(1'b0, 1'b1);
    n_checks++; if (block_line_state !== m_rows[3]) begin n_fail++; $display("FAIL ptr_row3: got %h expected %h", block_line_state, m_rows[3]); end
    repeat (13) pulse_ptr(1'b0, 1'b1);
    n_checks++; if (block_line_state !== m_rows[0]) begin n_fail++; $display("FAIL ptr_wrap: got %h expected %h", block_line_state, m_rows[0]); end
    repeat (2) pulse_ptr(1'b0, 1'b1);
    pulse_ptr(1'b1, 1'b1);
    n_checks++; if (block_line_state !== m_rows[0]) begin n_fail++; $display("FAIL ptr_coincident: got %h expected %h", block_line_state, m_rows[0]); end
    for (int k = 0; k < 60; k++) begin
      nf  = ($urandom_range(0, 7) == 0);
      gnl = $urandom_range(0, 1) == 1;
      pulse_ptr(nf, gnl);
      n_checks++;
      if (block_line_state !== m_rows[m_ptr]) begin n_fail++; $display("FAIL ptr_rand row%0d: got %h expected %h", m_ptr, block_line_state, m_rows[m_ptr]); end
    end
  endtask

  task automatic test_level_init_abort();
    bit a, h, e; int busy, acks_in_init;
    level_init = 1'b1;
    @(negedge clk);
    level_init = 1'b0;
    for (int i = 0; i < 40 && init_busy === 1'b1; i++) @(negedge clk);
    model_fill();
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL refill_count: got %0d expected %0d", blocks_remaining, m_count); end
    pulse_ptr(1'b1, 1'b0);
    repeat (9) pulse_ptr(1'b0, 1'b1);
    clear_row = 4'd9; clear_col = 4'd4; clear_req = 1'b1;
    @(negedge clk);
    n_checks++; if (clear_ack !== 1'b1) begin n_fail++; $display("FAIL abort_pre_ack: got %b expected 1", clear_ack); end
    level_init = 1'b1;
    #1;
    n_checks++; if (clear_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack: got %b expected 0", clear_ack); end
    @(negedge clk);
    level_init = 1'b0;
    n_checks++; if (init_busy !== 1'b1 || blocks_remaining !== 8'd0) begin n_fail++; $display("FAIL abort_init_entry: got busy %b count %0d expected busy 1 count 0", init_busy, blocks_remaining); end
    n_checks++; if (block_line_state !== m_rows[9]) begin n_fail++; $display("FAIL abort_no_write: got %h expected %h", block_line_state, m_rows[9]); end
    busy = 0; acks_in_init = 0;
    for (int i = 0; i < 40 && init_busy === 1'b1; i++) begin
      busy++;
      if (clear_ack === 1'b1) acks_in_init++;
      @(negedge clk);
    end
    n_checks++; if (busy != 16) begin n_fail++; $display("FAIL abort_init_cycles: got %0d expected 16", busy); end
    n_checks++; if (acks_in_init != 0) begin n_fail++; $display("FAIL abort_ack_during_init: got %0d expected 0", acks_in_init); end
    a = 1'b0; h = 1'b0;
    for (int i = 0; i < 6 && !a; i++) begin
      @(negedge clk);
      if (clear_ack === 1'b1) begin a = 1'b1; h = clear_hit; end
    end
    clear_req = 1'b0;
    @(negedge clk);
    e = model_clear(9, 4);
    n_checks++; if (a !== 1'b1 || h !== e) begin n_fail++; $display("FAIL held_req_after_init: got ack %b hit %b expected ack 1 hit %b", a, h, e); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL held_req_count: got %0d expected %0d", blocks_remaining, m_count); end
    n_checks++; if (block_line_state !== m_rows[9]) begin n_fail++; $display("FAIL held_req_row9: got %h expected %h", block_line_state, m_rows[9]); end
  endtask

  task automatic test_back_to_back();
    int acks, hits, adjacent;
    bit prev;
    level_init = 1'b1;
    @(negedge clk);
    level_init = 1'b0;
    for (int i = 0; i < 40 && init_busy === 1'b1; i++) @(negedge clk);
    model_fill();
    clear_row = 4'd0; clear_col = 4'd0; clear_req = 1'b1;
    acks = 0; hits = 0; adjacent = 0; prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (clear_ack === 1'b1) begin
        acks++;
        if (clear_hit === 1'b1) hits++;
        if (prev) adjacent++;
      end
      prev = (clear_ack === 1'b1);
    end
    clear_req = 1'b0;
    @(negedge clk);
    void'(model_clear(0, 0));
    n_checks++; if (acks != 3) begin n_fail++; $display("FAIL b2b_acks: got %0d expected 3", acks); end
    n_checks++; if (hits != 1) begin n_fail++; $display("FAIL b2b_hits: got %0d expected 1", hits); end
    n_checks++; if (adjacent != 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d adjacent acks expected 0", adjacent); end
    n_checks++; if (blocks_remaining !== 8'(m_count)) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", blocks_remaining, m_count); end
  endtask

  task automatic test_clear_all();
    bit a, h, e; int lat;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 13; c++) begin
        if (m_rows[r][c]) begin
          do_clear(r, c, a, h, lat);
          e = model_clear(r, c);
          n_checks++;
          if (a !== 1'b1 || h !== e) begin n_fail++; $display("FAIL clear_all r%0d c%0d: got ack %b hit %b expected ack 1 hit %b", r, c, a, h, e); end
        end
      end
    end
    n_checks++; if (blocks_remaining !== 8'(m_count) || m_count != 0) begin n_fail++; $display("FAIL clear_all_count: got %0d expected 0", blocks_remaining); end
    n_checks++; if (all_cleared !== 1'b1) begin n_fail++; $display("FAIL clear_all_flag: got %b expected 1", all_cleared); end
    do_clear(5, 5, a, h, lat);
    e = model_clear(5, 5);
    n_checks++; if (a !== 1'b1 || h !== e) begin n_fail++; $display("FAIL empty_clear: got ack %b hit %b expected ack 1 hit %b", a, h, e); end
    n_checks++; if (blocks_remaining !== 8'd0 || all_cleared !== 1'b1) begin n_fail++; $display("FAIL empty_count: got %0d flag %b expected 0 flag 1", blocks_remaining, all_cleared); end
  endtask

  initial begin
    test_reset();
    test_single_clear();
    test_miss();
    test_random_clears();
    test_row_pointer();
    test_level_init_abort();
    test_back_to_back();
    test_clear_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
